// File: rtl/alg_amba_vip_base_pkg.sv
// Shared types and constants for the AMBA VIP base fault checker.
package alg_amba_vip_base_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam int          LFSR_WIDTH    = 20;
   // Feedback taps on bits 19 and 16.
   localparam logic [19:0] LFSR_TAPS     = 20'h90000;
   localparam logic [19:0] LFSR_ZERO_SUB = 20'h00001;
   localparam int          LANE_WIDTH    = 32;

   // One Fibonacci step: shift left, new bit0 is the XOR of the tapped bits.
   function automatic logic [19:0] lfsr_next(input logic [19:0] cur);
      return {cur[18:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/alg_amba_vip_base_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module alg_amba_vip_base_popcount #(
   parameter int WIDTH = 128
) (
   input  logic [WIDTH-1:0]         bits,
   output logic [$clog2(WIDTH):0]   count
);

   localparam int OUT_W = $clog2(WIDTH) + 1;

   // Sum every set bit of the input.
   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + {{(OUT_W-1){1'b0}}, bits[i]};
      end
   end

endmodule

// File: rtl/alg_amba_vip_base_fault_check.sv
// Stream sink that applies LFSR backpressure, regenerates the expected
// lane pattern for beats of the programmed id and accumulates error stats.
// Pipeline: accept (t) -> stage 1 mask register (t+1) -> stage 2 stats (t+2).
// Handshake: a beat transfers on a cycle where s_valid and s_ready are both
// high and restart is low; s_ready never depends on s_valid.
module alg_amba_vip_base_fault_check
   import alg_amba_vip_base_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ID_WIDTH   = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic                  restart,
   input  logic [19:0]           seed,
   input  logic [19:0]           rdy_thres,
   input  logic                  stop_on_err,
   input  logic [ID_WIDTH-1:0]   id,
   input  logic [ID_WIDTH-1:0]   s_id,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  err_pulse,
   output logic                  halted,
   output logic [31:0]           stats_nbbeat,
   output logic [31:0]           stats_nbcheck,
   output logic [31:0]           stats_nberror,
   output logic [31:0]           stats_nbbiterr,
   output logic [31:0]           first_err_seq,
   output state_t                dbg_state
);

   localparam int NLANES = DATA_WIDTH / LANE_WIDTH;
   localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;

   state_t                state, state_nxt;
   logic [19:0]           lfsr;
   logic                  accept, match;
   logic [31:0]           seq;
   logic [DATA_WIDTH-1:0] expected;
   logic                  s1_valid, s1_check;
   logic [DATA_WIDTH-1:0] s1_mask;
   logic [31:0]           s1_seq;
   logic                  s2_err;
   logic [CNT_W-1:0]      bit_cnt;
   logic [32:0]           biterr_sum;
   logic                  err_seen;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state; a halt request from stage 2 outranks enable dropping.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = RUN;
         RUN: begin
            if (s2_err && stop_on_err) state_nxt = HALT;
            else if (!enable)          state_nxt = IDLE;
         end
         HALT:    if (restart) state_nxt = enable ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      s_ready   = (state == RUN) && (lfsr >= rdy_thres);
      halted    = (state == HALT);
      dbg_state = state;
   end

   // Handshake, id match and expected lane pattern for the current seq.
   always_comb begin
      accept   = s_valid && s_ready && !restart;
      match    = (s_id == id);
      expected = '0;
      for (int k = 0; k < NLANES; k++) begin
         expected[k*LANE_WIDTH +: LANE_WIDTH] = seq + 32'(k);
      end
   end

   // Backpressure LFSR: reload on restart, step every cycle in RUN.
   always_ff @(posedge clk) begin
      if (!rstn)             lfsr <= LFSR_ZERO_SUB;
      else if (restart)      lfsr <= (seed == '0) ? LFSR_ZERO_SUB : seed;
      else if (state == RUN) lfsr <= lfsr_next(lfsr);
   end

   // Stage 1: register the mismatch mask and the seq of the accepted beat.
   always_ff @(posedge clk) begin
      if (!rstn || restart) begin
         s1_valid <= 1'b0;
         s1_check <= 1'b0;
         s1_mask  <= '0;
         s1_seq   <= '0;
         seq      <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_check <= match;
            s1_mask  <= s_data ^ expected;
            s1_seq   <= seq;
            if (match) seq <= seq + 32'd1;
         end
      end
   end

   // Beat and check counters, visible the cycle after accept; both wrap.
   always_ff @(posedge clk) begin
      if (!rstn || restart) begin
         stats_nbbeat  <= '0;
         stats_nbcheck <= '0;
      end else if (accept) begin
         stats_nbbeat <= stats_nbbeat + 32'd1;
         if (match) stats_nbcheck <= stats_nbcheck + 32'd1;
      end
   end

   alg_amba_vip_base_popcount #(.WIDTH(DATA_WIDTH)) u_popcount (
      .bits  (s1_mask),
      .count (bit_cnt)
   );

   // Stage 2 error decode; a restart discards whatever sits in stage 1.
   always_comb begin
      s2_err     = s1_valid && s1_check && (|s1_mask) && !restart;
      biterr_sum = {1'b0, stats_nbbiterr} + 33'(bit_cnt);
   end

   // Stage 2: saturating error counters, first error capture, error pulse.
   always_ff @(posedge clk) begin
      if (!rstn || restart) begin
         err_pulse      <= 1'b0;
         stats_nberror  <= '0;
         stats_nbbiterr <= '0;
         first_err_seq  <= 32'hFFFF_FFFF;
         err_seen       <= 1'b0;
      end else begin
         err_pulse <= s2_err;
         if (s2_err) begin
            if (stats_nberror != 32'hFFFF_FFFF) stats_nberror <= stats_nberror + 32'd1;
            stats_nbbiterr <= biterr_sum[32] ? 32'hFFFF_FFFF : biterr_sum[31:0];
            if (!err_seen) begin
               first_err_seq <= s1_seq;
               err_seen      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alg_amba_vip_base_fault_check.sv
// Bench for alg_amba_vip_base_fault_check: drives beats with a scoreboard of
// expected err_pulse values and checks statistics after each scenario.
module tb_alg_amba_vip_base_fault_check;
   import alg_amba_vip_base_pkg::*;

   localparam int DW = 128;
   localparam int IW = 1;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          enable = 1'b0;
   logic          restart = 1'b0;
   logic [19:0]   seed = 20'd0;
   logic [19:0]   rdy_thres = 20'd0;
   logic          stop_on_err = 1'b0;
   logic [IW-1:0] id = '0;
   logic [IW-1:0] s_id = '0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready, err_pulse, halted;
   logic [31:0]   stats_nbbeat, stats_nbcheck, stats_nberror, stats_nbbiterr, first_err_seq;
   state_t        dbg_state;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [0:0]    exp_q[$];
   logic          acc_d1 = 1'b0;
   logic          acc_d2 = 1'b0;
   logic          bp_track = 1'b0;
   logic [19:0]   lfsr_m = 20'd1;

   alg_amba_vip_base_fault_check #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .enable         (enable),
      .restart        (restart),
      .seed           (seed),
      .rdy_thres      (rdy_thres),
      .stop_on_err    (stop_on_err),
      .id             (id),
      .s_id           (s_id),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .err_pulse      (err_pulse),
      .halted         (halted),
      .stats_nbbeat   (stats_nbbeat),
      .stats_nbcheck  (stats_nbcheck),
      .stats_nberror  (stats_nberror),
      .stats_nbbiterr (stats_nbbiterr),
      .first_err_seq  (first_err_seq),
      .dbg_state      (dbg_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] pattern(input logic [31:0] s);
      logic [DW-1:0] p;
      for (int k = 0; k < DW/32; k++) p[k*32 +: 32] = s + k;
      return p;
   endfunction

   // One cycle; when tracking backpressure, step the reference LFSR and
   // compare s_ready against it.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_track) begin
         lfsr_m = {lfsr_m[18:0], lfsr_m[19] ^ lfsr_m[16]};
         check_eq("bp_ready", {31'd0, s_ready}, {31'd0, lfsr_m >= rdy_thres});
      end
   endtask

   task automatic send(input logic [IW-1:0] bid, input logic [DW-1:0] d, input logic e);
      int n = 0;
      exp_q.push_back(e);
      s_id    = bid;
      s_data  = d;
      s_valid = 1'b1;
      while (!s_ready && n < 300) begin
         tick();
         n++;
      end
      if (!s_ready) begin
         check_eq("accept_timeout", {31'd0, s_ready}, 32'd1);
         void'(exp_q.pop_back());
      end else begin
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic restart_pulse();
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   task automatic drain();
      repeat (4) tick();
   endtask

   task automatic check_stats(input string tag, input logic [31:0] beat, input logic [31:0] chk,
                              input logic [31:0] err, input logic [31:0] bits, input logic [31:0] first);
      check_eq({tag, "_nbbeat"},   stats_nbbeat,   beat);
      check_eq({tag, "_nbcheck"},  stats_nbcheck,  chk);
      check_eq({tag, "_nberror"},  stats_nberror,  err);
      check_eq({tag, "_nbbiterr"}, stats_nbbiterr, bits);
      check_eq({tag, "_first"},    first_err_seq,  first);
   endtask

   // Scoreboard: each accepted beat must show its expected err_pulse two cycles later.
   always @(negedge clk) begin
      if (!rstn) begin
         acc_d1 <= 1'b0;
         acc_d2 <= 1'b0;
      end else begin
         if (acc_d2) begin
            if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            else                   check_eq("err_pulse", {31'd0, err_pulse}, {31'd0, exp_q.pop_front()});
         end else if (err_pulse) begin
            check_eq("err_spurious", {31'd0, err_pulse}, 32'd0);
         end
         acc_d2 <= acc_d1;
         acc_d1 <= s_valid && s_ready && !restart;
      end
   end

   initial begin
      logic [DW-1:0] d;
      int sq;

      // Reset state.
      repeat (3) tick();
      check_eq("rst_ready",  {31'd0, s_ready},   32'd0);
      check_eq("rst_err",    {31'd0, err_pulse}, 32'd0);
      check_eq("rst_halted", {31'd0, halted},    32'd0);
      check_eq("rst_state",  {30'd0, dbg_state}, 32'd0);
      check_stats("rst", 0, 0, 0, 0, 32'hFFFF_FFFF);
      rstn = 1'b1;

      // Clean stream, always ready.
      enable = 1'b1; rdy_thres = 20'd0; seed = 20'd1; id = '0;
      tick();
      restart_pulse();
      for (int i = 0; i < 8; i++) begin
         check_eq("clean_ready", {31'd0, s_ready}, 32'd1);
         send('0, pattern(i), 1'b0);
      end
      drain();
      check_stats("clean", 8, 8, 0, 0, 32'hFFFF_FFFF);

      // Single-bit fault on seq 3.
      restart_pulse();
      for (int i = 0; i < 6; i++) begin
         d = pattern(i);
         if (i == 3) d[5] = ~d[5];
         send('0, d, i == 3);
      end
      drain();
      check_stats("bit1", 6, 6, 1, 1, 3);

      // Whole-beat invert on seq 0.
      restart_pulse();
      send('0, ~pattern(0), 1'b1);
      send('0, pattern(1), 1'b0);
      drain();
      check_stats("inv", 2, 2, 1, 128, 0);

      // Mixed ids, garbage only on the unchecked id.
      restart_pulse();
      sq = 0;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) begin
            send('0, pattern(sq), 1'b0);
            sq++;
         end else begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            send('1, d, 1'b0);
         end
      end
      drain();
      check_stats("mixed", 10, 5, 0, 0, 32'hFFFF_FFFF);

      // Restart coinciding with a valid beat: the beat is dropped.
      s_id = '0; s_data = pattern(0); s_valid = 1'b1;
      restart_pulse();
      s_valid = 1'b0;
      drain();
      check_stats("rsacc", 0, 0, 0, 0, 32'hFFFF_FFFF);
      send('0, pattern(0), 1'b0);
      drain();
      check_stats("rsacc2", 1, 1, 0, 0, 32'hFFFF_FFFF);

      // Stop on error with back-to-back faulty beats.
      stop_on_err = 1'b1;
      restart_pulse();
      send('0, pattern(0), 1'b0);
      send('0, pattern(1), 1'b0);
      send('0, pattern(2) ^ 128'h1, 1'b1);
      send('0, pattern(3) ^ 128'h6, 1'b1);
      s_id = '0; s_data = pattern(4); s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("halt_ready", {31'd0, s_ready}, 32'd0);
         tick();
      end
      s_valid = 1'b0;
      check_eq("halt_halted", {31'd0, halted}, 32'd1);
      check_stats("halt", 4, 4, 2, 3, 2);
      restart_pulse();
      check_eq("rerun_halted", {31'd0, halted},    32'd0);
      check_eq("rerun_state",  {30'd0, dbg_state}, 32'd1);
      check_eq("rerun_ready",  {31'd0, s_ready},   32'd1);
      check_stats("rerun", 0, 0, 0, 0, 32'hFFFF_FFFF);
      stop_on_err = 1'b0;

      // Enable drops with beats in flight: they still complete.
      send('0, pattern(0), 1'b0);
      send('0, pattern(1) ^ 128'h100, 1'b1);
      enable = 1'b0;
      drain();
      check_eq("endrop_state", {30'd0, dbg_state}, 32'd0);
      check_eq("endrop_ready", {31'd0, s_ready},   32'd0);
      check_stats("endrop", 2, 2, 1, 1, 1);

      // Backpressure from a zero seed against a reference LFSR.
      enable = 1'b1; seed = 20'd0; rdy_thres = 20'h80000;
      restart_pulse();
      lfsr_m = 20'h00001;
      bp_track = 1'b1;
      check_eq("bp_ready0", {31'd0, s_ready}, {31'd0, lfsr_m >= rdy_thres});
      for (int i = 0; i < 12; i++) send('0, pattern(i), 1'b0);
      drain();
      bp_track = 1'b0;
      check_stats("bp", 12, 12, 0, 0, 32'hFFFF_FFFF);

      check_eq("sb_left", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alg_amba_vip_base_fault_check.md
# alg_amba_vip_base_fault_check

Self-checking stream sink that sits directly downstream of the fault-injection stage in the Allegro AMBA VIP bench. It consumes the id/data stream after faults have been injected and applies LFSR-driven backpressure. For beats whose id matches the programmed id, it regenerates the expected data pattern, compares it against the received data, and accumulates beat-error and bit-error statistics. Error counts from this block are cross-checked against the injector's own error counter to close the loop on fault coverage.

## Interface
- DATA_WIDTH, 128, stream data width; multiple of 32.
- ID_WIDTH, 1, stream id width.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- enable  in  1  run request; level-sensitive.
- restart  in  1  single-cycle pulse: clear stats, reload seeds, flush pipeline, leave HALT.
- seed  in  20  backpressure LFSR seed, loaded on restart; 0 is replaced by 20'h00001.
- rdy_thres  in  20  backpressure threshold; 0 means always ready.
- stop_on_err  in  1  enter HALT on first detected error.
- id  in  ID_WIDTH  id whose beats are checked.
- s_id  in  ID_WIDTH  input id.
- s_data  in  DATA_WIDTH  input data.
- s_valid  in  1  input valid.
- s_ready  out  1  input ready; reset 0.
- err_pulse  out  1  one-cycle pulse per erroneous beat; reset 0.
- halted  out  1  FSM in HALT; reset 0.
- stats_nbbeat  out  32  accepted beats, wraps; reset 0.
- stats_nbcheck  out  32  checked beats (id match), wraps; reset 0.
- stats_nberror  out  32  beats with at least one bit mismatch, saturating; reset 0.
- stats_nbbiterr  out  32  total mismatched bits, saturating; reset 0.
- first_err_seq  out  32  sequence number of the first erroneous beat; reset 32'hFFFF_FFFF.

## Operation
- FSM states: IDLE (reset state), RUN, HALT.
  - IDLE → RUN when enable=1.
  - RUN → IDLE when enable=0.
  - RUN → HALT when the stage-2 error and stop_on_err are both 1.
  - HALT → RUN on restart if enable=1, otherwise HALT → IDLE on restart.
- s_ready = (state==RUN) && (lfsr >= rdy_thres). s_ready is deasserted in IDLE and HALT.
- Backpressure LFSR:
  - 20-bit Fibonacci: new bit0 = bit19 ^ bit16; shift left.
  - Advances every cycle in RUN; holds otherwise.
  - Reset value 20'h00001.
- Accept = s_valid && s_ready. Every accept increments stats_nbbeat.
- Check applies only when s_id==id:
  - seq = internal 32-bit sequence counter, reset/restart to 0, +1 per checked beat, wraps.
  - Expected 32-bit lane k = seq + k (mod 2^32), for k = 0 .. DATA_WIDTH/32-1.
  - mask = s_data ^ expected. Error = |mask. Bit errors = popcount(mask).
- Non-matching ids are accepted and counted in stats_nbbeat only. They do not advance seq.
- On the first error after reset/restart, first_err_seq captures that beat's seq.
- Saturating counters stop at 32'hFFFF_FFFF.
- Width rules:
  - popcount result is $clog2(DATA_WIDTH)+1 bits.
  - Its sum with stats_nbbiterr is computed in 33 bits, then saturated.

## Timing
- Stage 1, cycle t+1 after accept at t: registered mask, check flag, seq.
- Stage 2, cycle t+2: counters, first_err_seq and halted updated; err_pulse high for that cycle.
- stats_nbbeat and stats_nbcheck update at t+1.
- Throughput is one beat per cycle with no bubbles when rdy_thres=0.
- HALT entry does not flush the pipeline. A beat already in stage 1 is still checked and counted; nothing new is accepted from the cycle the FSM is in HALT.
- Restart coinciding with an accept: restart wins. The beat is discarded and not counted; both pipeline stages are invalidated the next cycle.
- rstn low mid-operation: all state returns to reset values on the next edge. In-flight beats are lost.
- enable dropping while stage 1/2 hold beats: those beats still complete and are counted.

## Structure
- Shared package alg_amba_vip_base_pkg gets:
  - state enum: IDLE, RUN, HALT.
  - LFSR taps constant and LFSR_ZERO_SUB = 20'h00001.
  - LANE_WIDTH = 32.
- One sub-module: alg_amba_vip_base_popcount.
  - Parameter WIDTH.
  - Purely combinational, output $clog2(WIDTH)+1 bits.
  - Instantiated in stage 2 on the registered mask.

## Test plan
- Clean stream: rdy_thres=0, id=0, 8 beats id=0 carrying the correct pattern for seq 0..7 → s_ready constant 1; nbbeat=8, nbcheck=8, nberror=0, nbbiterr=0; first_err_seq=FFFF_FFFF.
- Single-bit fault: beat seq=3 with bit 5 flipped → err_pulse exactly 2 cycles after its accept; nberror=1, nbbiterr=1, first_err_seq=3.
- Whole-beat invert on beat seq=0, DATA_WIDTH=128 → nbbiterr=128, nberror=1.
- Mixed ids: alternate id=0 and id=1 over 10 beats, with faults only on the id=1 beats → nbcheck=5, nberror=0, nbbeat=10.
- stop_on_err=1: errors on seq 2 and 3, back-to-back → halted=1, both errors counted (nberror=2), s_ready=0. Restart with enable=1 → RUN, all stats 0, first_err_seq=FFFF_FFFF.
- Backpressure: seed=0, rdy_thres=20'h80000 → LFSR starts at 20'h00001. The s_ready pattern matches a reference LFSR model cycle-for-cycle, and no beat is lost or duplicated.
